// File: rtl/link_uart.sv
// link_uart: full-duplex UART behind the SB (data) / SC (control-status) bus registers, internal baud generator.
// Latency: reads land on outdata 1 cycle after load; UART_TX drops on the edge that accepts the start store.
// Backpressure: none; an SC start is ignored while TX is busy, an unread RX byte is overwritten and overrun set.
// Optional feature: define LINK_PARITY_EN for an even-parity bit on TX and RX (SC bit3 = parity_err).
module link_uart #(
   parameter int unsigned CLOCK_DIV = 36,
   parameter int unsigned DATA_BITS = 8,
   parameter logic [15:0] SB_ADDR   = 16'hff01,
   parameter logic [15:0] SC_ADDR   = 16'hff02
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  indata,
   output logic [7:0]  outdata,
   input  logic        load,
   input  logic        store,
   output logic        irq,
   input  logic        UART_RX,
   output logic        UART_TX
);
   localparam int unsigned CW = $clog2(CLOCK_DIV);
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLOCK_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLOCK_DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;

   // Transmit side
   tx_state_e              tx_state_q, tx_state_d;
   logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]          tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
   logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
   logic                   tx_line_q, tx_line_d;
   logic                   tx_end;

   // Receive side
   logic                   rx_meta_q, rx_meta_d;
   logic                   rx_sync_q, rx_sync_d;
   logic                   rx_last_q, rx_last_d;
   rx_state_e              rx_state_q, rx_state_d;
   logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]          rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
   logic                   rx_fin_q, rx_fin_d;
   logic                   rx_ok_q, rx_ok_d;

   // Register file and bus
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   overrun_q, overrun_d;
   logic                   frame_err_q, frame_err_d;
   logic [7:0]             outdata_q, outdata_d;
   logic                   irq_q, irq_d;
   logic                   sb_wr, sc_wr, sb_rd, sc_rd, bus_rd, tx_go, rx_good;
   logic [7:0]             status;

`ifdef LINK_PARITY_EN
   logic                   tx_par_q, tx_par_d;
   logic                   rx_par_q, rx_par_d;
   logic                   rx_perr_q, rx_perr_d;
   logic                   parity_err_q, parity_err_d;
`endif

   // Bus decode: store wins over load; a start is only taken when the transmitter is idle
   always_comb begin
      sb_wr  = store && (address == SB_ADDR);
      sc_wr  = store && (address == SC_ADDR);
      bus_rd = load && !store;
      sb_rd  = bus_rd && (address == SB_ADDR);
      sc_rd  = bus_rd && (address == SC_ADDR);
      tx_go  = sc_wr && indata[7] && (tx_state_q == TX_IDLE);
   end

   // TX FSM: start, data LSB-first, optional parity, stop; each bit held CLOCK_DIV cycles
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_line_d  = tx_line_q;
      tx_end     = 1'b0;
`ifdef LINK_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      if (tx_state_q == TX_IDLE) begin
         if (tx_go) begin
            // Snapshot tx_data so later SB writes only affect the next frame
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = tx_data_q;
            tx_line_d  = 1'b0;
`ifdef LINK_PARITY_EN
            tx_par_d   = ^tx_data_q;
`endif
         end
      end else if (tx_cnt_q != CNT_LAST) begin
         tx_cnt_d = tx_cnt_q + CW'(1);
      end else begin
         tx_cnt_d = '0;
         case (tx_state_q)
            TX_START: begin
               tx_state_d = TX_DATA;
               tx_line_d  = tx_shift_q[0];
            end
            TX_DATA: begin
               if (tx_bit_q != BIT_LAST) begin
                  tx_bit_d   = tx_bit_q + BW'(1);
                  tx_shift_d = tx_shift_q >> 1;
                  tx_line_d  = tx_shift_q[1];
               end else begin
`ifdef LINK_PARITY_EN
                  tx_state_d = TX_PARITY;
                  tx_line_d  = tx_par_q;
`else
                  tx_state_d = TX_STOP;
                  tx_line_d  = 1'b1;
`endif
               end
            end
            TX_PARITY: begin
               tx_state_d = TX_STOP;
               tx_line_d  = 1'b1;
            end
            TX_STOP: begin
               tx_state_d = TX_IDLE;
               tx_end     = 1'b1;
            end
            default: begin
               tx_state_d = TX_IDLE;
               tx_line_d  = 1'b1;
            end
         endcase
      end
   end

   // RX FSM: synchronise, detect falling edge, confirm start at half-bit, then sample once per bit
   always_comb begin
      rx_meta_d  = UART_RX;
      rx_sync_d  = rx_meta_q;
      rx_last_d  = rx_sync_q;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_fin_d   = 1'b0;
      rx_ok_d    = rx_ok_q;
`ifdef LINK_PARITY_EN
      rx_par_d   = rx_par_q;
      rx_perr_d  = rx_perr_q;
`endif
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_last_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_q != CNT_HALF) begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end else begin
               // Line back high at mid-start is a glitch: drop it silently
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q != CNT_LAST) begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end else begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q != BIT_LAST) begin
                  rx_bit_d = rx_bit_q + BW'(1);
               end else begin
`ifdef LINK_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end
            end
         end
         RX_PARITY: begin
            if (rx_cnt_q != CNT_LAST) begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end else begin
               rx_cnt_d   = '0;
               rx_state_d = RX_STOP;
`ifdef LINK_PARITY_EN
               rx_par_d   = rx_sync_q;
`endif
            end
         end
         RX_STOP: begin
            if (rx_cnt_q != CNT_LAST) begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end else begin
               // Result is committed to the registers on the following edge
               rx_cnt_d   = '0;
               rx_fin_d   = 1'b1;
`ifdef LINK_PARITY_EN
               rx_perr_d  = (^rx_shift_q) ^ rx_par_q;
               rx_ok_d    = rx_sync_q && !((^rx_shift_q) ^ rx_par_q);
`else
               rx_ok_d    = rx_sync_q;
`endif
               rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_sync_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Register updates, status flags, read mux and interrupt
   always_comb begin
      tx_data_d   = sb_wr ? indata[DATA_BITS-1:0] : tx_data_q;
      rx_good     = rx_fin_q && rx_ok_q;
      rx_data_d   = rx_good ? rx_shift_q : rx_data_q;
      // A read racing a completion returns the old byte, the new one stays valid
      rx_valid_d  = (rx_valid_q && !sb_rd) || rx_good;
      overrun_d   = (overrun_q && !sc_wr) || (rx_good && rx_valid_q && !sb_rd);
      frame_err_d = (frame_err_q && !sc_wr) || (rx_fin_q && !rx_ok_q);
      irq_d       = tx_end || rx_fin_q;
      status      = {tx_state_q != TX_IDLE, rx_valid_q, overrun_q, frame_err_q, 4'b0000};
`ifdef LINK_PARITY_EN
      parity_err_d = (parity_err_q && !sc_wr) || (rx_fin_q && rx_perr_q);
      status[3]    = parity_err_q;
`endif
      outdata_d = outdata_q;
      if (sb_rd) begin
         outdata_d = '0;
         outdata_d[DATA_BITS-1:0] = rx_data_q;
      end else if (sc_rd) begin
         outdata_d = status;
      end else if (bus_rd) begin
         outdata_d = '0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         tx_data_q   <= '0;
         tx_line_q   <= 1'b1;
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_last_q   <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         rx_fin_q    <= 1'b0;
         rx_ok_q     <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         outdata_q   <= '0;
         irq_q       <= 1'b0;
`ifdef LINK_PARITY_EN
         tx_par_q     <= 1'b0;
         rx_par_q     <= 1'b0;
         rx_perr_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         tx_data_q   <= tx_data_d;
         tx_line_q   <= tx_line_d;
         rx_meta_q   <= rx_meta_d;
         rx_sync_q   <= rx_sync_d;
         rx_last_q   <= rx_last_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_fin_q    <= rx_fin_d;
         rx_ok_q     <= rx_ok_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         outdata_q   <= outdata_d;
         irq_q       <= irq_d;
`ifdef LINK_PARITY_EN
         tx_par_q     <= tx_par_d;
         rx_par_q     <= rx_par_d;
         rx_perr_q    <= rx_perr_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign outdata = outdata_q;
   assign irq     = irq_q;
   assign UART_TX = tx_line_q;

endmodule
